// File: rtl/rm_feed_pkg.sv
// rm_feed_pkg: shared types and widths for the instruction feeder
package rm_feed_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, DONE} feed_state_t;
  localparam int INSTR_W = 16;
endpackage

// File: rtl/instr_ram.sv
// instr_ram: program store, one synchronous write port and an asynchronous read port
module instr_ram
  import rm_feed_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW = 5
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);
  logic [INSTR_W-1:0] mem [DEPTH];
  // contents survive reset so a loaded program can be rerun
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_feeder.sv
// instr_feeder: steps a stored program into the cpu, one instruction per w handshake
module instr_feeder
  import rm_feed_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW = 5,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               run,
  input  logic [AW:0]        len,
  input  logic               cpu_w,
  output logic               cpu_s,
  output logic               cpu_load,
  output logic [INSTR_W-1:0] cpu_in,
  output logic [AW-1:0]      pc,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  feed_state_t state, state_d;
  logic [AW-1:0] pc_d;
  logic [AW:0] len_q, len_d, len_c;
  logic [CW-1:0] cnt, cnt_d;
  logic [INSTR_W-1:0] in_d, rdata;
  logic busy_d, done_d, err_d, hit, idle;
  assign idle = state == IDLE || state == DONE;
  assign cpu_s = state == ISSUE;
  assign cpu_load = state == ISSUE || state == WAIT_ACK;
  assign len_c = len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : len;
  assign hit = state == WAIT_ACK ? !cpu_w : cpu_w;
  // reading at the next pc lets cpu_in be captured on the edge that enters ISSUE
  instr_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk), .we(prog_we && idle), .waddr(prog_addr), .wdata(prog_data),
    .raddr(pc_d), .rdata(rdata)
  );
  // next-state and next-register logic for the issue/handshake sequence
  always_comb begin
    state_d = state;
    pc_d = pc;
    cnt_d = cnt;
    len_d = len_q;
    busy_d = busy;
    done_d = done;
    err_d = err;
    case (state)
      IDLE, DONE: if (run) begin
        len_d = len_c;
        pc_d = '0;
        err_d = 1'b0;
        done_d = len_c == '0;
        busy_d = len_c != '0;
        state_d = len_c == '0 ? DONE : ISSUE;
      end
      ISSUE: begin
        cnt_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK, WAIT_DONE: if (hit) begin
        cnt_d = '0;
        state_d = state == WAIT_ACK ? WAIT_DONE : NEXT;
      end else if (cnt == CW'(TIMEOUT - 1)) begin
        err_d = 1'b1;
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = DONE;
      end else cnt_d = cnt + 1'b1;
      NEXT: if ({1'b0, pc} == len_q - 1'b1) begin
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = DONE;
      end else begin
        pc_d = pc + 1'b1;
        state_d = ISSUE;
      end
      default: state_d = IDLE;
    endcase
    in_d = state_d == ISSUE ? rdata : cpu_in;
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      cnt <= '0;
      len_q <= '0;
      cpu_in <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      pc <= pc_d;
      cnt <= cnt_d;
      len_q <= len_d;
      cpu_in <= in_d;
      busy <= busy_d;
      done <= done_d;
      err <= err_d;
    end
  end
endmodule

// File: tb/tb_instr_feeder.sv
// tb_instr_feeder: randomized scoreboard bench for instr_feeder with a behavioural cpu stub
module tb_instr_feeder;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam int TO = 8;
  typedef struct packed {logic [AW-1:0] pc; logic [15:0] ins;} iss_t;
  typedef struct packed {logic err; logic [AW-1:0] pc;} cmp_t;

  logic clk = 0, reset, prog_we, run, cpu_w, cpu_s, cpu_load, busy, done, err;
  logic [AW-1:0] prog_addr, pc;
  logic [15:0] prog_data, cpu_in;
  logic [AW:0] len;

  int checks = 0, errors = 0, n_iss = 0;
  iss_t iss_q[$];
  cmp_t cmp_q[$];
  logic [15:0] mem_ref [DEPTH];
  logic [15:0] r [8];
  logic fn, fz, fv, hang = 0, stub_busy, done_prev = 0;
  logic [15:0] last_in = '0;

  instr_feeder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .run(run), .len(len), .cpu_w(cpu_w), .cpu_s(cpu_s), .cpu_load(cpu_load), .cpu_in(cpu_in),
    .pc(pc), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // tiny model of the cpu: MOV Rn,#imm8 and ADD Rd,Rn,Rm with flags
  task automatic exec(input logic [15:0] i);
    logic [15:0] a, b, s;
    if (i[15:11] == 5'b11010) r[i[10:8]] = {{8{i[7]}}, i[7:0]};
    else if (i[15:11] == 5'b10100) begin
      a = r[i[10:8]];
      b = r[i[2:0]];
      s = a + b;
      r[i[7:5]] = s;
      fz = s == 0;
      fn = s[15];
      fv = (a[15] == b[15]) && (s[15] != a[15]);
    end
  endtask

  // cpu stub: leaves wait a random time after s, then retires a random time later
  initial begin
    cpu_w = 1;
    stub_busy = 0;
    forever begin
      @(negedge clk);
      if (cpu_s && !hang && !reset) begin
        stub_busy = 1;
        exec(cpu_in);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        cpu_w = 0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        cpu_w = 1;
        stub_busy = 0;
      end
    end
  end

  // monitor: pops expected issues and completions as the DUT presents them
  always @(negedge clk) begin
    iss_t ie;
    cmp_t ce;
    if (!reset) begin
      if (cpu_s) begin
        n_iss++;
        if (iss_q.size() == 0) fail("unexpected_issue");
        else begin
          ie = iss_q.pop_front();
          chk("issue_pc", pc, ie.pc);
          chk("issue_instr", cpu_in, ie.ins);
        end
        last_in = cpu_in;
      end else if (busy) chk("instr_stable", cpu_in, last_in);
      if (done && !done_prev) begin
        if (cmp_q.size() == 0) fail("unexpected_done");
        else begin
          ce = cmp_q.pop_front();
          chk("done_err", err, ce.err);
          chk("done_pc", pc, ce.pc);
          chk("done_busy", busy, 0);
        end
      end
    end
    done_prev = done;
  end

  task automatic wr(input int a, input logic [15:0] d);
    prog_addr = AW'(a);
    prog_data = d;
    prog_we = 1;
    mem_ref[a] = d;
    @(negedge clk);
    prog_we = 0;
  endtask

  task automatic pulse(input int l);
    len = (AW+1)'(l);
    run = 1;
    @(negedge clk);
    run = 0;
  endtask

  // reference: a run of length l issues min(l, DEPTH) words from address 0 in order
  task automatic go(input int l);
    int n = l > DEPTH ? DEPTH : l;
    for (int i = 0; i < n; i++) iss_q.push_back({AW'(i), mem_ref[i]});
    cmp_q.push_back({1'b0, AW'(n == 0 ? 0 : n - 1)});
    pulse(l);
  endtask

  task automatic finish_prog(input string nm);
    int t = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_done"}, done, 1);
    @(negedge clk);
    chk({nm, "_issues_left"}, iss_q.size(), 0);
    chk({nm, "_done_left"}, cmp_q.size(), 0);
    t = 0;
    while (stub_busy && t < 100) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic rst_pulse();
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_s", cpu_s, 0);
    chk("rst_load", cpu_load, 0);
    chk("rst_pc", pc, 0);
    chk("rst_in", cpu_in, 0);
  endtask

  initial begin
    int base, t;
    reset = 1;
    prog_we = 0;
    prog_addr = '0;
    prog_data = '0;
    run = 0;
    len = '0;
    repeat (2) @(negedge clk);
    reset = 0;
    // reset leaves RAM intact
    wr(0, 16'hD105);
    rst_pulse();
    r[1] = 0;
    go(1);
    finish_prog("rerun_after_reset");
    chk("r1_after_reset", r[1], 16'h0005);
    // three-instruction program
    wr(1, 16'hD203);
    wr(2, 16'hA162);
    base = n_iss;
    go(3);
    finish_prog("three");
    chk("three_pulses", n_iss - base, 3);
    chk("three_r3", r[3], 16'h0008);
    chk("three_nzv", {fn, fz, fv}, 3'b000);
    chk("three_pc", pc, 2);
    // zero length from IDLE
    rst_pulse();
    base = n_iss;
    go(0);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("len0_pulses", n_iss - base, 0);
    chk("len0_left", cmp_q.size(), 0);
    // abort during WAIT_DONE of instruction 1, then rerun
    iss_q.push_back({AW'(0), mem_ref[0]});
    iss_q.push_back({AW'(1), mem_ref[1]});
    pulse(3);
    t = 0;
    while (!(busy && pc == 1 && !cpu_load && !cpu_s && !cpu_w) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reached", t < 200, 1);
    rst_pulse();
    chk("abort_issues_left", iss_q.size(), 0);
    base = n_iss;
    repeat (12) @(negedge clk);
    chk("abort_no_s", n_iss - base, 0);
    r[1] = 0;
    go(1);
    finish_prog("abort_rerun");
    chk("abort_r1", r[1], 16'h0005);
    // hung cpu: w stays high after issue
    hang = 1;
    iss_q.push_back({AW'(0), mem_ref[0]});
    cmp_q.push_back({1'b1, AW'(0)});
    pulse(3);
    t = 0;
    while (!cpu_s && t < 20) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("timeout_cycles", t, TO + 1);
    chk("timeout_err", err, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_pc", pc, 0);
    hang = 0;
    @(negedge clk);
    chk("timeout_left", cmp_q.size(), 0);
    // writes and run while busy are ignored
    for (int i = 0; i < 6; i++) wr(i, 16'($urandom));
    go(6);
    @(negedge clk);
    prog_addr = AW'(1);
    prog_data = ~mem_ref[1];
    prog_we = 1;
    len = 6'd1;
    run = 1;
    @(negedge clk);
    prog_we = 0;
    run = 0;
    finish_prog("interrupt");
    // random programs including full and over-length runs
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < DEPTH; i++) wr(i, 16'($urandom));
      go(k == 0 ? 32 : k == 1 ? 40 : int'($urandom_range(1, 40)));
      finish_prog("random");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
